// File: rtl/pmos_bias_trim_ctrl_pkg.sv
// Shared types, default parameters and the thermometer helper for the PMOS bias trim controller.
package pmos_bias_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CODE_W_DEF     = 4;
    localparam int CODE_MIN_DEF   = 1;
    localparam int CODE_MAX_DEF   = 10;
    localparam int SETTLE_CYC_DEF = 16;

    // One bit of the thermometer code: finger idx is on when code exceeds idx.
    function automatic logic therm_encode_bit(input int code, input int idx);
        return (code > idx) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/pmos_bias_trim_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous analog comparator outputs; both stages reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_r;
    logic s2_r;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

endmodule

// File: rtl/pmos_bias_trim_ctrl.sv
// PMOS bias finger sweep: step the trim code up from CODE_MIN, settle, sample the comparator, lock on first trip.
// Build option PMOS_BIAS_TRIM_MAJ3_EN: decide each step on the majority of three consecutive samples.
module pmos_bias_trim_ctrl
    import pmos_bias_pkg::*;
#(
    parameter int CODE_W     = CODE_W_DEF,
    parameter int CODE_MIN   = CODE_MIN_DEF,
    parameter int CODE_MAX   = CODE_MAX_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cmp_in,
    output logic [CODE_W-1:0]   trim_code,
    output logic [CODE_MAX-1:0] finger_en,
    output logic                busy,
    output logic                done,
    output logic                locked,
    output logic [CODE_W-1:0]   result_code
);

    localparam int                CNT_W    = $clog2(SETTLE_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CODE_W-1:0] CMIN     = CODE_W'(CODE_MIN);
    localparam logic [CODE_W-1:0] CMAX     = CODE_W'(CODE_MAX);

    if (CODE_MAX >= (1 << CODE_W)) begin : g_chk_code_w
        $error("CODE_MAX must be below 2**CODE_W");
    end
    if (SETTLE_CYC < 2) begin : g_chk_settle
        $error("SETTLE_CYC must be at least 2");
    end

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [CODE_W-1:0]     trim_r, trim_s;
    logic [CODE_W-1:0]     result_r, result_s;
    logic [CODE_MAX-1:0]   finger_r, finger_s, finger_min_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  locked_r, locked_s;
    logic                  cmp_s;
    logic                  decide_s;
    logic                  hit_s;
`ifdef PMOS_BIAS_TRIM_MAJ3_EN
    logic [1:0]            samp_r, samp_s;
    logic [1:0]            votes_r, votes_s;
`endif

    sync2 u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (cmp_s)
    );

    // Next-state and next-output logic of the sweep FSM.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        trim_s   = trim_r;
        result_s = result_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        locked_s = locked_r;
        decide_s = 1'b0;
        hit_s    = 1'b0;
`ifdef PMOS_BIAS_TRIM_MAJ3_EN
        samp_s   = samp_r;
        votes_s  = votes_r;
`endif
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
                if (start) begin
                    trim_s   = CMIN;
                    locked_s = 1'b0;
                    cnt_s    = {CNT_W{1'b0}};
                    busy_s   = 1'b1;
                    state_s  = SETTLE;
                end else begin
                    state_s  = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = SAMPLE;
`ifdef PMOS_BIAS_TRIM_MAJ3_EN
                    samp_s  = 2'd0;
                    votes_s = 2'd0;
`endif
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            SAMPLE: begin
`ifdef PMOS_BIAS_TRIM_MAJ3_EN
                // Third sample completes the vote; earlier ones just accumulate.
                if (samp_r == 2'd2) begin
                    decide_s = 1'b1;
                    hit_s    = ((votes_r + {1'b0, cmp_s}) >= 2'd2);
                end else begin
                    samp_s  = samp_r + 2'd1;
                    votes_s = votes_r + {1'b0, cmp_s};
                end
`else
                decide_s = 1'b1;
                hit_s    = cmp_s;
`endif
                if (decide_s) begin
                    if (hit_s) begin
                        result_s = trim_r;
                        locked_s = 1'b1;
                        busy_s   = 1'b0;
                        done_s   = 1'b1;
                        state_s  = DONE;
                    end else if (trim_r < CMAX) begin
                        trim_s  = trim_r + CODE_W'(1);
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = SETTLE;
                    end else begin
                        result_s = CMAX;
                        locked_s = 1'b0;
                        busy_s   = 1'b0;
                        done_s   = 1'b1;
                        state_s  = DONE;
                    end
                end else begin
                    state_s = SAMPLE;
                end
            end
            DONE: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // Finger enables track the next trim code so both registers change together.
    always_comb begin
        finger_s     = {CODE_MAX{1'b0}};
        finger_min_s = {CODE_MAX{1'b0}};
        for (int i = 0; i < CODE_MAX; i++) begin
            finger_s[i]     = therm_encode_bit(int'(trim_s), i);
            finger_min_s[i] = therm_encode_bit(CODE_MIN, i);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            trim_r   <= CMIN;
            finger_r <= finger_min_s;
            result_r <= {CODE_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            locked_r <= 1'b0;
`ifdef PMOS_BIAS_TRIM_MAJ3_EN
            samp_r   <= 2'd0;
            votes_r  <= 2'd0;
`endif
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            trim_r   <= trim_s;
            finger_r <= finger_s;
            result_r <= result_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            locked_r <= locked_s;
`ifdef PMOS_BIAS_TRIM_MAJ3_EN
            samp_r   <= samp_s;
            votes_r  <= votes_s;
`endif
        end
    end

    assign trim_code   = trim_r;
    assign finger_en   = finger_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign locked      = locked_r;
    assign result_code = result_r;

endmodule

// File: tb/tb_pmos_bias_trim_ctrl.sv
// Self-checking bench for pmos_bias_trim_ctrl: per-cycle comparison against a sweep-timeline model plus directed literal checks.
module tb_pmos_bias_trim_ctrl;

    localparam int CODE_W     = 4;
    localparam int CODE_MIN   = 1;
    localparam int CODE_MAX   = 10;
    localparam int SETTLE_CYC = 16;
`ifdef PMOS_BIAS_TRIM_MAJ3_EN
    localparam int NSAMP = 3;
`else
    localparam int NSAMP = 1;
`endif
    localparam int STEP = SETTLE_CYC + NSAMP;
    localparam int LIM  = CODE_MAX * STEP + 10;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                cmp_in = 1'b0;
    logic [CODE_W-1:0]   trim_code;
    logic [CODE_MAX-1:0] finger_en;
    logic                busy, done, locked;
    logic [CODE_W-1:0]   result_code;

    pmos_bias_trim_ctrl #(
        .CODE_W(CODE_W), .CODE_MIN(CODE_MIN), .CODE_MAX(CODE_MAX), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cmp_in(cmp_in),
        .trim_code(trim_code), .finger_en(finger_en), .busy(busy), .done(done),
        .locked(locked), .result_code(result_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // Analog plant knobs
    int thr       = 99;
    bit glitch_en = 1'b0;
    int force_k   = -1;

    // Model: a sweep is a timeline of k edges since start; every STEP edges a decision is taken
    // from comparator values seen two (and three, four) edges earlier through the synchroniser.
    bit m_active = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_locked = 1'b0;
    int m_k = 0, m_code = CODE_MIN, m_result = 0;
    bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0, h4 = 1'b0;

    always @(posedge clk) begin
        bit dec;
        if (rst) begin
            m_active = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_locked = 1'b0;
            m_k = 0; m_code = CODE_MIN; m_result = 0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0; h4 = 1'b0;
        end else begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1; m_busy = 1'b1; m_k = 0; m_code = CODE_MIN; m_locked = 1'b0;
                end
            end else begin
                m_k++;
                if (m_k % STEP == 0) begin
                    dec = (NSAMP == 1) ? h2 : ((int'(h2) + int'(h3) + int'(h4)) >= 2);
                    if (dec) begin
                        m_result = m_code; m_locked = 1'b1;
                        m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                    end else if (m_code < CODE_MAX) begin
                        m_code++;
                    end else begin
                        m_result = CODE_MAX; m_locked = 1'b0;
                        m_active = 1'b0; m_busy = 1'b0; m_done = 1'b1;
                    end
                end
            end
            h4 = h3; h3 = h2; h2 = h1; h1 = cmp_in;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [CODE_MAX-1:0] ef;
        if (check_en) begin
            ef = CODE_MAX'((1 << m_code) - 1);
            n_checks++;
            if (trim_code === CODE_W'(m_code) && finger_en === ef && busy === m_busy &&
                done === m_done && locked === m_locked && result_code === CODE_W'(m_result))
                n_pass++;
            else
                $display("FAIL cycle t=%0t dut/model: trim %0d/%0d finger %b/%b busy %b/%b done %b/%b locked %b/%b result %0d/%0d",
                         $time, trim_code, m_code, finger_en, ef, busy, m_busy, done, m_done,
                         locked, m_locked, result_code, m_result);
        end
    end

    // Comparator plant: trips once the applied code reaches thr, with optional glitches
    initial begin
        forever begin
            @(negedge clk);
            cmp_in = (m_code >= thr);
            if (glitch_en && $urandom_range(0, 7) == 0) cmp_in = ~cmp_in;
            if (force_k >= 0 && m_active && m_k == force_k) cmp_in = 1'b1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic run_sweep(input int thr_v, input int poke, output int lat, output int busy_n);
        bit seen;
        @(negedge clk);
        thr = thr_v; start = 1'b1; lat = 1; busy_n = 0; seen = 1'b0;
        while (!seen && lat <= LIM) begin
            @(negedge clk);
            start = (lat == poke);
            lat++;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            n_checks++;
            $display("FAIL sweep_timeout: no done within %0d cycles (thr %0d)", LIM, thr_v);
        end
    endtask

    initial begin
        int lat, bn, exp_code, guard;
        @(negedge clk);
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_trim", int'(trim_code), 1);
        chk("reset_finger", int'(finger_en), 10'b0000000001);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_result", int'(result_code), 0);
        rst = 1'b0;

        // Mid-range lock with a start pulse inside the sweep that must be ignored
        run_sweep(6, 40, lat, bn);
        chk("mid_result", int'(result_code), 6);
        chk("mid_locked", int'(locked), 1);
        chk("mid_finger", int'(finger_en), 10'b0000111111);
        chk("mid_latency", lat, 5 * STEP + STEP + 2);

        // Never trips
        run_sweep(99, 0, lat, bn);
        chk("nolock_result", int'(result_code), 10);
        chk("nolock_locked", int'(locked), 0);
        chk("nolock_trim", int'(trim_code), 10);
        chk("nolock_finger", int'(finger_en), 10'b1111111111);
        chk("nolock_latency", lat, 10 * STEP + 2);

        // Trips immediately
        run_sweep(0, 0, lat, bn);
        chk("imm_result", int'(result_code), 1);
        chk("imm_latency", lat, STEP + 2);
        chk("imm_busy_cycles", bn, STEP);

        // Reset while the sweep sits at code 4
        @(negedge clk);
        thr = 99; start = 1'b1;
        @(negedge clk);
        start = 1'b0; guard = 0;
        while (trim_code != 4'd4 && guard < LIM) begin
            @(negedge clk);
            guard++;
        end
        chk("pre_rst_trim", int'(trim_code), 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_trim", int'(trim_code), 1);
        chk("rst_mid_busy", int'(busy), 0);
        run_sweep(2, 0, lat, bn);
        chk("after_rst_result", int'(result_code), 2);
        chk("after_rst_latency", lat, 2 * STEP + 2);

        // One-cycle comparator glitch landing on a code-3 sample
        force_k = 3 * STEP - 3;
`ifdef PMOS_BIAS_TRIM_MAJ3_EN
        exp_code = 5;
`else
        exp_code = 3;
`endif
        run_sweep(5, 0, lat, bn);
        force_k = -1;
        chk("glitch_result", int'(result_code), exp_code);
        chk("glitch_locked", int'(locked), 1);
        chk("glitch_latency", lat, exp_code * STEP + 2);

        // Random traffic: starts, resets, noisy comparator, varying thresholds
        glitch_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 30) == 0);
            rst   = ($urandom_range(0, 400) == 0);
            if (done) thr = $urandom_range(0, 12);
        end
        start = 1'b0; rst = 1'b0; glitch_en = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
